// File: rtl/rv32_pkg.sv
// Shared encodings for the memory arbiter: access widths, FSM states and byte-enable patterns.
package rv32_pkg;

    typedef enum logic [1:0] {
        BYTE       = 2'b00,
        HALF       = 2'b01,
        WORD       = 2'b10,
        WL_ILLEGAL = 2'b11
    } word_len_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IF_ACC = 2'd1,
        LS_ACC = 2'd2,
        ERR    = 2'd3
    } arb_state_e;

    localparam logic [3:0] BE_NONE = 4'b0000;
    localparam logic [3:0] BE_BYTE = 4'b0001;
    localparam logic [3:0] BE_HALF = 4'b0011;
    localparam logic [3:0] BE_WORD = 4'b1111;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the fetch unit, the load/store unit, the memory port and the arbiter.
interface mem_arbiter_if #(
    parameter int ADDR_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_valid;
    logic [31:0]       if_rdata;

    logic              ls_req;
    logic              ls_we;
    logic [ADDR_W-1:0] ls_addr;
    logic [31:0]       ls_wdata;
    logic [1:0]        ls_word_length;
    logic              ls_gnt;
    logic              ls_valid;
    logic [31:0]       ls_rdata;
    logic              ls_misalign;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [3:0]        mem_be;
    logic              mem_ready;
    logic [31:0]       mem_rdata;
    logic              timeout;

    modport slave (
        input  if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, ls_word_length,
               mem_ready, mem_rdata,
        output if_gnt, if_valid, if_rdata, ls_gnt, ls_valid, ls_rdata, ls_misalign,
               mem_req, mem_we, mem_addr, mem_wdata, mem_be, timeout
    );

    modport master (
        output if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, ls_word_length,
               mem_ready, mem_rdata,
        input  if_gnt, if_valid, if_rdata, ls_gnt, ls_valid, ls_rdata, ls_misalign,
               mem_req, mem_we, mem_addr, mem_wdata, mem_be, timeout
    );

endinterface

// File: rtl/mem_lane_steer.sv
// Combinational lane steering for load/store accesses: byte enables, write-data replication
// and misalignment detection.
module mem_lane_steer
    import rv32_pkg::*;
(
    input  logic [1:0]  word_length,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_steer,
    output logic        misalign
);

    always_comb begin
        be          = BE_NONE;
        wdata_steer = wdata;
        misalign    = 1'b0;
        case (word_length)
            BYTE: begin
                be          = BE_BYTE << addr_lo;
                wdata_steer = {4{wdata[7:0]}};
            end
            HALF: begin
                be          = BE_HALF << {addr_lo[1], 1'b0};
                wdata_steer = {2{wdata[15:0]}};
                misalign    = addr_lo[0];
            end
            WORD: begin
                be       = BE_WORD;
                misalign = (addr_lo != 2'b00);
            end
            default: misalign = 1'b1;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between fetch and load/store requesters, with access timeout.
// Define MEM_ARB_RR_EN to break simultaneous-request ties round-robin instead of favouring ls.
module mem_arbiter
    import rv32_pkg::*;
#(
    parameter int TIMEOUT_CYC = 255,
    parameter int ADDR_W      = 32
) (
    input  logic         clk,
    input  logic         rst,
    mem_arbiter_if.slave bus
);
    // state  | meaning
    // IDLE   | nothing in flight; grants issued combinationally here
    // IF_ACC | fetch read presented on the memory port
    // LS_ACC | load/store presented on the memory port
    // ERR    | one-cycle rejection of a misaligned load/store

    localparam int               CNT_W      = $clog2(TIMEOUT_CYC + 2);
    localparam bit               TO_EN      = (TIMEOUT_CYC != 0);
    localparam logic [CNT_W-1:0] CNT_TC     = CNT_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

    arb_state_e       state;
    logic [CNT_W-1:0] wait_cnt;
    logic [3:0]       steer_be;
    logic [31:0]      steer_wdata;
    logic             steer_misalign;
    logic             pick_ls;
    logic             grant_ls;
    logic             grant_if;
    logic             in_acc;
    logic             done;
    logic             expired;

    mem_lane_steer u_steer (
        .word_length (bus.ls_word_length),
        .addr_lo     (bus.ls_addr[1:0]),
        .wdata       (bus.ls_wdata),
        .be          (steer_be),
        .wdata_steer (steer_wdata),
        .misalign    (steer_misalign)
    );

`ifdef MEM_ARB_RR_EN
    logic last_ls;

    // On a tie, whoever won last time yields.
    always_comb pick_ls = bus.ls_req && !(bus.if_req && last_ls);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)           last_ls <= 1'b0;
        else if (grant_ls) last_ls <= 1'b1;
        else if (grant_if) last_ls <= 1'b0;
    end
`else
    always_comb pick_ls = bus.ls_req;
`endif

    assign grant_ls    = (state == IDLE) && !rst && pick_ls;
    assign grant_if    = (state == IDLE) && !rst && bus.if_req && !pick_ls;
    assign bus.ls_gnt  = grant_ls;
    assign bus.if_gnt  = grant_if;
    assign in_acc      = (state == IF_ACC) || (state == LS_ACC);
    assign bus.mem_req = in_acc;
    assign done        = in_acc && bus.mem_ready;
    // A ready on the last allowed wait cycle still completes the access.
    assign expired     = TO_EN && in_acc && !bus.mem_ready && (wait_cnt == CNT_TC);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            wait_cnt        <= '0;
            bus.mem_we      <= 1'b0;
            bus.mem_addr    <= '0;
            bus.mem_wdata   <= '0;
            bus.mem_be      <= BE_NONE;
            bus.if_valid    <= 1'b0;
            bus.if_rdata    <= '0;
            bus.ls_valid    <= 1'b0;
            bus.ls_rdata    <= '0;
            bus.ls_misalign <= 1'b0;
            bus.timeout     <= 1'b0;
        end else begin
            bus.if_valid    <= 1'b0;
            bus.ls_valid    <= 1'b0;
            bus.ls_misalign <= 1'b0;
            bus.timeout     <= 1'b0;
            case (state)
                IDLE: begin
                    wait_cnt <= '0;
                    if (grant_ls && steer_misalign) begin
                        state           <= ERR;
                        bus.ls_valid    <= 1'b1;
                        bus.ls_misalign <= 1'b1;
                        bus.ls_rdata    <= '0;
                    end else if (grant_ls) begin
                        state         <= LS_ACC;
                        bus.mem_we    <= bus.ls_we;
                        bus.mem_addr  <= bus.ls_addr & ALIGN_MASK;
                        bus.mem_wdata <= steer_wdata;
                        bus.mem_be    <= steer_be;
                    end else if (grant_if) begin
                        state         <= IF_ACC;
                        bus.mem_we    <= 1'b0;
                        bus.mem_addr  <= bus.if_addr & ALIGN_MASK;
                        bus.mem_wdata <= '0;
                        bus.mem_be    <= BE_WORD;
                    end
                end
                IF_ACC, LS_ACC: begin
                    wait_cnt <= wait_cnt + 1'b1;
                    if (done || expired) begin
                        state       <= IDLE;
                        bus.timeout <= expired;
                        if (state == IF_ACC) begin
                            bus.if_valid <= 1'b1;
                            bus.if_rdata <= done ? bus.mem_rdata : '0;
                        end else begin
                            bus.ls_valid <= 1'b1;
                            bus.ls_rdata <= (done && !bus.mem_we) ? bus.mem_rdata : '0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized traffic against a
// transaction-level reference model.
module tb_mem_arbiter;
    import rv32_pkg::*;

    localparam int TO = 4;
`ifdef MEM_ARB_RR_EN
    localparam bit RR_EN = 1'b1;
`else
    localparam bit RR_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDR_W(32)) bus ();

    mem_arbiter #(.TIMEOUT_CYC(TO), .ADDR_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, want 0x%08h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [31:0] lanes(input logic [31:0] d, input int sz);
        logic [31:0] r;
        for (int k = 0; k < 4; k++) r[k*8 +: 8] = d[(k % sz)*8 +: 8];
        return r;
    endfunction

    // Reference model: 0 = free, 1 = memory access outstanding, 2 = rejection cycle.
    int          m_busy = 0;
    int          m_waited = 0;
    bit          m_is_ls = 0;
    bit          m_last_ls = 0;
    logic [31:0] m_addr = '0;
    logic        m_we = 1'b0;
    logic [31:0] m_wdata = '0;
    logic [3:0]  m_be = '0;
    bit          r_if = 0, r_ls = 0, r_mis = 0, r_to = 0;
    logic [31:0] r_rdata = '0;
    bit          seen_ls_gnt = 0, seen_if_gnt = 0;

    always @(negedge clk) begin : model_chk
        logic e_ls, e_if;
        int   sz, lo;
        if (rst) begin
            chk("rst_ctrl", {24'b0, bus.if_gnt, bus.ls_gnt, bus.mem_req, bus.mem_we,
                             bus.if_valid, bus.ls_valid, bus.ls_misalign, bus.timeout}, 32'd0);
            chk("rst_data", {31'b0, |{bus.mem_addr, bus.mem_wdata, bus.mem_be,
                                      bus.if_rdata, bus.ls_rdata}}, 32'd0);
            m_busy = 0; m_last_ls = 0;
            r_if = 0; r_ls = 0; r_mis = 0; r_to = 0;
            seen_ls_gnt = 0; seen_if_gnt = 0;
        end else begin
            e_ls = 1'b0;
            e_if = 1'b0;
            if (m_busy == 0) begin
                if (bus.ls_req && bus.if_req) begin
                    if (RR_EN && m_last_ls) e_if = 1'b1;
                    else                    e_ls = 1'b1;
                end else begin
                    e_ls = bus.ls_req;
                    e_if = bus.if_req;
                end
            end
            chk("gnt", {30'b0, bus.ls_gnt, bus.if_gnt}, {30'b0, e_ls, e_if});
            chk("mem_req", {31'b0, bus.mem_req}, {31'b0, m_busy == 1});
            if (m_busy == 1) begin
                chk("mem_addr", bus.mem_addr, m_addr);
                chk("mem_be", {28'b0, bus.mem_be}, {28'b0, m_be});
                chk("mem_we", {31'b0, bus.mem_we}, {31'b0, m_we});
                if (m_we) chk("mem_wdata", bus.mem_wdata, m_wdata);
            end
            chk("resp_flags", {28'b0, bus.if_valid, bus.ls_valid, bus.ls_misalign, bus.timeout},
                {28'b0, r_if, r_ls, r_mis, r_to});
            if (r_if) chk("if_rdata", bus.if_rdata, r_rdata);
            if (r_ls) chk("ls_rdata", bus.ls_rdata, r_rdata);

            r_if = 0; r_ls = 0; r_mis = 0; r_to = 0;
            if (m_busy == 2) begin
                m_busy = 0;
            end else if (m_busy == 1) begin
                if (bus.mem_ready) begin
                    m_busy  = 0;
                    r_rdata = m_we ? 32'd0 : bus.mem_rdata;
                    if (m_is_ls) r_ls = 1; else r_if = 1;
                end else begin
                    m_waited++;
                    if (m_waited == TO) begin
                        m_busy  = 0;
                        r_to    = 1;
                        r_rdata = '0;
                        if (m_is_ls) r_ls = 1; else r_if = 1;
                    end
                end
            end
            if (e_ls) begin
                m_last_ls = 1;
                sz = 1 << bus.ls_word_length;
                lo = int'(bus.ls_addr[1:0]);
                if (bus.ls_word_length == 2'b11 || (lo % sz) != 0) begin
                    m_busy = 2; r_ls = 1; r_mis = 1; r_rdata = '0;
                end else begin
                    m_busy = 1; m_waited = 0; m_is_ls = 1;
                    m_addr  = {bus.ls_addr[31:2], 2'b00};
                    m_we    = bus.ls_we;
                    m_be    = 4'(((1 << sz) - 1) << lo);
                    m_wdata = lanes(bus.ls_wdata, sz);
                end
            end else if (e_if) begin
                m_last_ls = 0;
                m_busy = 1; m_waited = 0; m_is_ls = 0;
                m_addr = {bus.if_addr[31:2], 2'b00};
                m_we   = 1'b0;
                m_be   = 4'hF;
            end
            seen_ls_gnt = bus.ls_gnt;
            seen_if_gnt = bus.if_gnt;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        bus.if_req = 0; bus.ls_req = 0; bus.mem_ready = 1;
        repeat (n) cyc();
        bus.mem_ready = 0;
    endtask

    task automatic ls_drive(input logic we, input logic [31:0] a, input logic [31:0] d,
                            input logic [1:0] wl);
        bus.ls_req = 1; bus.ls_we = we; bus.ls_addr = a; bus.ls_wdata = d;
        bus.ls_word_length = wl;
    endtask

    task automatic t_tie();
        int got = 0;
        int guard = 0;
        bit want_ls;
        ls_drive(1'b0, 32'h400, 32'h0, 2'b10);
        bus.if_req = 1; bus.if_addr = 32'h500; bus.mem_ready = 1;
        while (got < 4 && guard < 40) begin
            #1;
            if (bus.ls_gnt || bus.if_gnt) begin
                want_ls = RR_EN ? (got % 2 == 0) : 1'b1;
                chk($sformatf("tie_%0d", got), {30'b0, bus.ls_gnt, bus.if_gnt},
                    want_ls ? 32'd2 : 32'd1);
                got++;
            end
            cyc();
            guard++;
        end
        chk("tie_count", got, 32'd4);
        idle(3);
    endtask

    task automatic t_load_word();
        ls_drive(1'b0, 32'h100, 32'h0, 2'b10);
        #1 chk("lw_gnt", {31'b0, bus.ls_gnt}, 32'd1);
        cyc(); bus.ls_req = 0;
        #1 chk("lw_be", {28'b0, bus.mem_be}, 32'hF);
        chk("lw_addr", bus.mem_addr, 32'h100);
        chk("lw_req", {31'b0, bus.mem_req}, 32'd1);
        cyc(); cyc();
        bus.mem_ready = 1; bus.mem_rdata = 32'hDEADBEEF;
        cyc(); bus.mem_ready = 0; bus.mem_rdata = 32'h0;
        #1 chk("lw_valid", {31'b0, bus.ls_valid}, 32'd1);
        chk("lw_rdata", bus.ls_rdata, 32'hDEADBEEF);
        chk("lw_req_off", {31'b0, bus.mem_req}, 32'd0);
        cyc();
        #1 chk("lw_pulse", {31'b0, bus.ls_valid}, 32'd0);
    endtask

    task automatic t_store_byte();
        ls_drive(1'b1, 32'h203, 32'h000000A5, 2'b00);
        #1 chk("sb_gnt", {31'b0, bus.ls_gnt}, 32'd1);
        cyc(); bus.ls_req = 0;
        #1 chk("sb_be", {28'b0, bus.mem_be}, 32'h8);
        chk("sb_addr", bus.mem_addr, 32'h200);
        chk("sb_wdata", bus.mem_wdata, 32'hA5A5A5A5);
        chk("sb_we", {31'b0, bus.mem_we}, 32'd1);
        bus.mem_ready = 1; bus.mem_rdata = 32'h12345678;
        cyc(); bus.mem_ready = 0;
        #1 chk("sb_valid", {31'b0, bus.ls_valid}, 32'd1);
        chk("sb_rdata", bus.ls_rdata, 32'd0);
        cyc();
    endtask

    logic [31:0] mis_addr [3] = '{32'h101, 32'h102, 32'h100};
    logic [1:0]  mis_wl   [3] = '{2'b01, 2'b10, 2'b11};

    task automatic t_misalign();
        for (int i = 0; i < 3; i++) begin
            ls_drive(1'b0, mis_addr[i], 32'h0, mis_wl[i]);
            bus.mem_rdata = 32'hFFFF0000;
            #1 chk($sformatf("mis%0d_gnt", i), {31'b0, bus.ls_gnt}, 32'd1);
            cyc(); bus.ls_req = 0;
            #1 chk($sformatf("mis%0d_resp", i),
                   {29'b0, bus.mem_req, bus.ls_valid, bus.ls_misalign}, 32'd3);
            chk($sformatf("mis%0d_rdata", i), bus.ls_rdata, 32'd0);
            cyc();
            #1 chk($sformatf("mis%0d_end", i), {30'b0, bus.mem_req, bus.ls_valid}, 32'd0);
        end
    endtask

    task automatic t_timeout();
        bus.if_req = 1; bus.if_addr = 32'h43; bus.mem_ready = 0; bus.mem_rdata = 32'hCAFEF00D;
        #1 chk("to_gnt", {31'b0, bus.if_gnt}, 32'd1);
        cyc(); bus.if_req = 0;
        #1 chk("to_addr", bus.mem_addr, 32'h40);
        for (int i = 0; i < TO; i++) begin
            chk($sformatf("to_req%0d", i), {31'b0, bus.mem_req}, 32'd1);
            cyc();
            #1;
        end
        chk("to_resp", {29'b0, bus.mem_req, bus.if_valid, bus.timeout}, 32'd3);
        chk("to_rdata", bus.if_rdata, 32'd0);
        cyc();
    endtask

    task automatic t_reset_mid();
        ls_drive(1'b0, 32'h300, 32'h0, 2'b10);
        bus.mem_ready = 0;
        #1 chk("rm_gnt", {31'b0, bus.ls_gnt}, 32'd1);
        cyc(); bus.ls_req = 0;
        cyc();
        #1 chk("rm_req_on", {31'b0, bus.mem_req}, 32'd1);
        rst = 1;
        #1 chk("rm_req_off", {31'b0, bus.mem_req}, 32'd0);
        cyc();
        rst = 0; bus.if_req = 1; bus.if_addr = 32'h80;
        #1 chk("rm_if_gnt", {30'b0, bus.if_gnt, bus.ls_valid}, 32'd2);
        cyc(); bus.if_req = 0; bus.mem_ready = 1; bus.mem_rdata = 32'h0BADF00D;
        #1 chk("rm_no_ls", {31'b0, bus.ls_valid}, 32'd0);
        cyc(); bus.mem_ready = 0;
        #1 chk("rm_if_valid", {31'b0, bus.if_valid}, 32'd1);
        chk("rm_if_rdata", bus.if_rdata, 32'h0BADF00D);
    endtask

    task automatic t_random(input int n);
        for (int c = 0; c < n; c++) begin
            cyc();
            if (rst) rst = 0;
            else if ($urandom_range(0, 399) == 0) rst = 1;
            if (!bus.ls_req || seen_ls_gnt) begin
                bus.ls_req         = 1'($urandom_range(0, 1));
                bus.ls_we          = 1'($urandom_range(0, 1));
                bus.ls_addr        = $urandom;
                bus.ls_wdata       = $urandom;
                bus.ls_word_length = 2'($urandom_range(0, 3));
            end
            if (!bus.if_req || seen_if_gnt) begin
                bus.if_req  = 1'($urandom_range(0, 1));
                bus.if_addr = $urandom;
            end
            bus.mem_ready = ($urandom_range(0, 9) < 3);
            bus.mem_rdata = $urandom;
        end
        rst = 0;
    endtask

    initial begin
        bus.if_req = 0; bus.if_addr = '0;
        bus.ls_req = 0; bus.ls_we = 0; bus.ls_addr = '0; bus.ls_wdata = '0;
        bus.ls_word_length = 2'b00; bus.mem_ready = 0; bus.mem_rdata = '0;
        rst = 1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_state", {28'b0, bus.mem_req, bus.ls_valid, bus.if_valid, bus.timeout}, 32'd0);
        rst = 0;
        idle(2);
        t_tie();
        t_load_word();
        t_store_byte();
        t_misalign();
        t_timeout();
        t_reset_mid();
        idle(3);
        t_random(3000);
        idle(4);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
